// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes symbolic instructions into MIPS words and streams them into instruction memory
// Optional feature macro: ENC_SPECIAL2_EN (adds MUL/CLO/CLZ encodings)
module instr_encoder_loader #(
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              InValid,
   output logic              InReady,
   input  logic [5:0]        InOp,
   input  logic [4:0]        InRs,
   input  logic [4:0]        InRt,
   input  logic [4:0]        InRd,
   input  logic [4:0]        InShamt,
   input  logic [15:0]       InImm,
   input  logic [25:0]       InTarget,
   input  logic              InLast,
   output logic              MemWrite,
   output logic [ADDR_W-1:0] MemAddr,
   output logic [31:0]       MemData,
   output logic              CpuReset,
   output logic              Done,
   output logic              Error
);
   typedef enum logic [1:0] {LOAD, DONE, ERR} state_t;
   state_t state, state_nx;
   logic [ADDR_W-1:0] addr, addr_nx;
   logic [31:0] enc;
   logic legal, take;
   assign InReady  = state == LOAD;
   assign CpuReset = state != DONE;
   assign Done     = state == DONE;
   assign Error    = state == ERR;
   assign take     = InValid & InReady;
   // translate the mnemonic code and fields into a 32-bit word; flag codes with no encoding
   always_comb begin
      enc   = 32'h0;
      legal = 1'b1;
      case (InOp)
         6'd0:  enc = 32'h0;
         6'd1:  enc = {6'd0, InRs, InRt, InRd, InShamt, 6'd32};
         6'd2:  enc = {6'd0, InRs, InRt, InRd, InShamt, 6'd33};
         6'd3:  enc = {6'd0, InRs, InRt, InRd, InShamt, 6'd34};
         6'd4:  enc = {6'd0, InRs, InRt, InRd, InShamt, 6'd35};
         6'd5:  enc = {6'd0, InRs, InRt, InRd, InShamt, 6'd36};
         6'd6:  enc = {6'd0, InRs, InRt, InRd, InShamt, 6'd37};
         6'd7:  enc = {6'd0, InRs, InRt, InRd, InShamt, 6'd38};
         6'd8:  enc = {6'd0, InRs, InRt, InRd, InShamt, 6'd39};
         6'd9:  enc = {6'd0, InRs, InRt, InRd, InShamt, 6'd42};
         6'd10: enc = {6'd0, InRs, InRt, InRd, InShamt, 6'd43};
         6'd11: enc = {6'd0, 5'd0, InRt, InRd, InShamt, 6'd0};
         6'd12: enc = {6'd0, InRs, InRt, InRd, 5'd0, 6'd4};
         6'd13: enc = {6'd0, 5'd1, InRt, InRd, InShamt, 6'd2};
         6'd14: enc = {6'd0, InRs, InRt, InRd, 5'd1, 6'd6};
         6'd15: enc = {6'd0, InRs, 15'd0, 6'd8};
         6'd16: enc = {6'd0, InRs, InRt, InRd, InShamt, 6'd10};
         6'd17: enc = {6'd8, InRs, InRt, InImm};
         6'd18: enc = {6'd9, InRs, InRt, InImm};
         6'd19: enc = {6'd12, InRs, InRt, InImm};
         6'd20: enc = {6'd13, InRs, InRt, InImm};
         6'd21: enc = {6'd14, InRs, InRt, InImm};
         6'd22: enc = {6'd10, InRs, InRt, InImm};
         6'd23: enc = {6'd4, InRs, InRt, InImm};
         6'd24: enc = {6'd5, InRs, InRt, InImm};
         6'd25: enc = {6'd1, InRs, 5'd0, InImm};
         6'd26: enc = {6'd1, InRs, 5'd1, InImm};
         6'd27: enc = {6'd7, InRs, 5'd0, InImm};
         6'd28: enc = {6'd35, InRs, InRt, InImm};
         6'd29: enc = {6'd43, InRs, InRt, InImm};
         6'd30: enc = {6'd2, InTarget};
         6'd31: enc = {6'd3, InTarget};
`ifdef ENC_SPECIAL2_EN
         6'd32: enc = {6'd28, InRs, InRt, InRd, 5'd0, 6'd2};
         6'd33: enc = {6'd28, InRs, InRd, InRd, 5'd0, 6'd33};
         6'd34: enc = {6'd28, InRs, InRd, InRd, 5'd0, 6'd32};
`endif
         default: legal = 1'b0;
      endcase
   end
   // advance the write pointer and decide when loading finishes or faults
   always_comb begin
      state_nx = state;
      addr_nx  = addr;
      if (take) begin
         if (!legal) state_nx = ERR;
         else if (InLast) state_nx = DONE;
         else if (addr == {ADDR_W{1'b1}}) state_nx = ERR;
         else addr_nx = addr + 1'b1;
      end
   end
   // state, pointer and registered memory write port; reset drops any pending write
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state    <= LOAD;
         addr     <= ADDR_W'(BASE_ADDR);
         MemWrite <= 1'b0;
         MemAddr  <= '0;
         MemData  <= 32'h0;
      end else begin
         state    <= state_nx;
         addr     <= addr_nx;
         MemWrite <= take & legal;
         if (take & legal) begin
            MemAddr <= addr;
            MemData <= enc;
         end
      end
   end
endmodule
